dp_regfile_alu: RTL and testbench
=================================

// Module: dp_regfile_alu
// PURPOSE
//  Parametrised successor to the 4-bit accumulator datapath. Adds an NREGS x WIDTH register file,
//  8-op ALU with registered N/V/Z/C flags, and valid/ready handshakes on the command and result sides.
//  Sits between a sequencer issuing commands and a consumer of results. Latency: 1 cycle, multi-cycle MUL optional.
// PARAMETERS
//  WIDTH  8  datapath/register width in bits (>=2)
//  NREGS  4  register-file depth; power of 2, >=2; AW = $clog2(NREGS)
// PORTS
//  clk         in   1      rising-edge clock, the only clock
//  rst         in   1      synchronous, active-high reset
//  in_valid    in   1      command valid
//  in_ready    out  1      command accepted when in_valid && in_ready
//  in_op       in   3      opcode (see BEHAVIOUR)
//  in_rd       in   AW     destination register, also operand A
//  in_rs       in   AW     source register for operand B
//  in_use_imm  in   1      1: B = in_imm, 0: B = reg[in_rs]
//  in_imm      in   WIDTH  immediate operand
//  out_valid   out  1      result valid
//  out_ready   in   1      result consumed when out_valid && out_ready
//  out_data    out  WIDTH  result value
//  out_rd      out  AW     register the result was written to
//  flags       out  4      {N,V,Z,C}, registered
//  dbg_addr    in   AW     debug read address
//  dbg_data    out  WIDTH  combinational reg[dbg_addr]; pre-edge value
// BEHAVIOUR
//  Reset: all regs 0, flags 0, out_valid 0, out_data 0, out_rd 0, FSM IDLE. Overrides any operation in flight.
//  in_ready = (state==IDLE) && (!out_valid || out_ready). Output stage holds data stable while stalled.
//  On accept: A = reg[in_rd], B per in_use_imm; result computed combinationally.
//    Same edge: reg[in_rd], flags, out_data, out_rd written; out_valid set.
//    Back-to-back dependent commands therefore need no forwarding.
//  out_valid clears on out handshake unless a new command is accepted on the same edge.
//  Ops: 000 AND, 001 OR, 010 XOR, 011 ADD (A+B), 100 SUB (A-B = A+~B+1), 101 ADC (A+B+C), 110 MOV (B), 111 MUL/NOP.
//  Arithmetic: WIDTH-bit result, wraps modulo 2^WIDTH.
//  Flags: Z = result==0; N = result[WIDTH-1].
//    ADD/ADC: C = carry out. SUB: C = carry of A+~B+1, i.e. 1 = no borrow.
//    V = signed overflow for ADD/SUB/ADC, else 0. Logic ops and MOV: C=0, V=0.
//  rd==rs is legal: operands are read before the write.
// CONFIGURATION
//  Macro DP_MUL_EN defined: op 111 = MUL, a shift-add FSM.
//    IDLE -> BUSY on accept; counter runs WIDTH cycles; BUSY -> DONE; DONE writes low WIDTH bits of A*B
//    to reg[rd]/out_data, sets out_valid, -> IDLE.
//    C = 1 if upper product half != 0; V = 0; Z/N from low half. in_ready = 0 during BUSY/DONE.
//    rst during BUSY aborts with no register or flag write.
//  Macro undefined: op 111 = NOP. out_valid pulses with out_data 0, out_rd = in_rd; no reg/flag write; FSM stays IDLE.
// STRUCTURE
//  Package dp_pkg: opcode localparams/enum (OP_AND..OP_MUL), flag bit indices (FLG_N/V/Z/C), FSM state typedef.
//  Sub-module dp_alu_core: combinational single-cycle ALU (a, b, cin, op -> result, n, v, z, c).
//  Top holds the register file, output stage, flags register and MUL FSM.
// TESTING (WIDTH=8, NREGS=4)
//  1. MOV r0,#FF; ADD r0,#01 -> out_data 00, flags N0 V0 Z1 C1, dbg r0=00.
//  2. MOV r1,#00; SUB r1,#01 -> FF, N1 C0 Z0; MOV r2,#7F; ADD r2,#01 -> 80, V1 N1.
//  3. Back-to-back: MOV r3,#05 then ADD r3,r3 (rs=3) on next cycle -> 0A, no stall.
//  4. Backpressure: out_ready=0 for 3 cycles -> in_ready 0, out_data/out_rd stable, second cmd accepted after release.
//  5. rst asserted while out_valid=1 -> next cycle out_valid 0, flags 0, all dbg reads 00.
//  6. With DP_MUL_EN: MUL r0(#10),#10 -> in_ready low 8+ cycles, out 00, C1 Z1. Without the macro: op 111 leaves r0 and flags unchanged.

Source files
------------

// File: rtl/dp_regfile_alu_pkg.sv
// Shared definitions for the register-file ALU datapath: opcodes, flag bit
// positions, sequencer states and a flag-packing helper.
package dp_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_OR  = 3'd1,
        OP_XOR = 3'd2,
        OP_ADD = 3'd3,
        OP_SUB = 3'd4,
        OP_ADC = 3'd5,
        OP_MOV = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_V = 2;
    localparam int FLG_N = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [3:0] pack_flags(input logic n, input logic v,
                                              input logic z, input logic c);
        return {n, v, z, c};
    endfunction

endpackage

// File: rtl/dp_alu_core.sv
// Combinational single-cycle ALU: logic ops, ADD/SUB/ADC with carry and
// signed overflow, MOV. Opcode 111 yields zero here; the top handles it.
module dp_alu_core
    import dp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             n,
    output logic             v,
    output logic             z,
    output logic             c
);

    logic [WIDTH:0] sum_s;

    // Operation select and flag generation
    always_comb begin
        sum_s  = '0;
        result = '0;
        v      = 1'b0;
        c      = 1'b0;
        case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_ADD: begin
                sum_s  = {1'b0, a} + {1'b0, b};
                result = sum_s[WIDTH-1:0];
                c      = sum_s[WIDTH];
                v      = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            // Carry here means "no borrow"
            OP_SUB: begin
                sum_s  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                result = sum_s[WIDTH-1:0];
                c      = sum_s[WIDTH];
                v      = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADC: begin
                sum_s  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                result = sum_s[WIDTH-1:0];
                c      = sum_s[WIDTH];
                v      = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MOV: result = b;
            default: result = '0;
        endcase
        z = (result == '0);
        n = result[WIDTH-1];
    end

endmodule

// File: rtl/dp_regfile_alu.sv
// Register-file ALU datapath with valid/ready command and result handshakes.
// Optional macro DP_MUL_EN turns opcode 111 into a multi-cycle shift-add MUL.
module dp_regfile_alu
    import dp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [AW-1:0]    in_rd,
    input  logic [AW-1:0]    in_rs,
    input  logic             in_use_imm,
    input  logic [WIDTH-1:0] in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AW-1:0]    out_rd,
    output logic [3:0]       flags,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    logic [WIDTH-1:0] regs_r [NREGS];
    logic [3:0]       flags_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [AW-1:0]    out_rd_r;
    state_e           state_r;

    logic             accept_s;
    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_n_s;
    logic             alu_v_s;
    logic             alu_z_s;
    logic             alu_c_s;

    assign in_ready  = (state_r == ST_IDLE) && (!out_valid_r || out_ready);
    assign accept_s  = in_valid && in_ready;
    assign a_s       = regs_r[in_rd];
    assign b_s       = in_use_imm ? in_imm : regs_r[in_rs];
    assign dbg_data  = regs_r[dbg_addr];
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_rd    = out_rd_r;
    assign flags     = flags_r;

    dp_alu_core #(.WIDTH(WIDTH)) u_alu (
        .a      (a_s),
        .b      (b_s),
        .cin    (flags_r[FLG_C]),
        .op     (in_op),
        .result (alu_res_s),
        .n      (alu_n_s),
        .v      (alu_v_s),
        .z      (alu_z_s),
        .c      (alu_c_s)
    );

`ifdef DP_MUL_EN
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mul_acc_r;
    logic [2*WIDTH-1:0] mul_mcand_r;
    logic [WIDTH-1:0]   mul_mplier_r;
    logic [AW-1:0]      mul_rd_r;
    logic [CW-1:0]      mul_cnt_r;
    logic [WIDTH-1:0]   mul_lo_s;
    logic               mul_hi_nz_s;

    assign mul_lo_s    = mul_acc_r[WIDTH-1:0];
    assign mul_hi_nz_s = |mul_acc_r[2*WIDTH-1:WIDTH];
`endif

    // Register file, flags, output stage and MUL sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
            flags_r     <= 4'b0000;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_rd_r    <= '0;
            state_r     <= ST_IDLE;
`ifdef DP_MUL_EN
            mul_acc_r    <= '0;
            mul_mcand_r  <= '0;
            mul_mplier_r <= '0;
            mul_rd_r     <= '0;
            mul_cnt_r    <= '0;
`endif
        end else begin
            if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (in_op == OP_MUL) begin
`ifdef DP_MUL_EN
                            mul_acc_r    <= '0;
                            mul_mcand_r  <= {{WIDTH{1'b0}}, a_s};
                            mul_mplier_r <= b_s;
                            mul_rd_r     <= in_rd;
                            mul_cnt_r    <= '0;
                            state_r      <= ST_BUSY;
`else
                            out_valid_r <= 1'b1;
                            out_data_r  <= '0;
                            out_rd_r    <= in_rd;
`endif
                        end else begin
                            regs_r[in_rd] <= alu_res_s;
                            flags_r       <= pack_flags(alu_n_s, alu_v_s, alu_z_s, alu_c_s);
                            out_data_r    <= alu_res_s;
                            out_rd_r      <= in_rd;
                            out_valid_r   <= 1'b1;
                        end
                    end
                end
`ifdef DP_MUL_EN
                // One multiplier bit per cycle, LSB first
                ST_BUSY: begin
                    if (mul_mplier_r[0]) begin
                        mul_acc_r <= mul_acc_r + mul_mcand_r;
                    end
                    mul_mcand_r  <= mul_mcand_r << 1;
                    mul_mplier_r <= mul_mplier_r >> 1;
                    mul_cnt_r    <= mul_cnt_r + CW'(1);
                    if (mul_cnt_r == CW'(WIDTH - 1)) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    regs_r[mul_rd_r] <= mul_lo_s;
                    flags_r          <= pack_flags(mul_lo_s[WIDTH-1], 1'b0,
                                                   (mul_lo_s == '0), mul_hi_nz_s);
                    out_data_r       <= mul_lo_s;
                    out_rd_r         <= mul_rd_r;
                    out_valid_r      <= 1'b1;
                    state_r          <= ST_IDLE;
                end
`endif
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dp_regfile_alu.sv
// Randomized self-checking bench for dp_regfile_alu (WIDTH=8, NREGS=4) against
// an arithmetic reference model; honours DP_MUL_EN the same way as the design.
module tb_dp_regfile_alu;

    localparam int W   = 8;
    localparam int NR  = 4;
    localparam int AW  = 2;
    localparam int TOP = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [AW-1:0] in_rd;
    logic [AW-1:0] in_rs;
    logic          in_use_imm;
    logic [W-1:0]  in_imm;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [AW-1:0] out_rd;
    logic [3:0]    flags;
    logic [AW-1:0] dbg_addr;
    logic [W-1:0]  dbg_data;

    int         n_chk  = 0;
    int         n_pass = 0;
    int         m_regs [NR];
    logic [3:0] m_flags;
    int         exp_data;
    int         exp_rd;
    bit         bp_rand;
    int         last_stalls;

    always #5 clk = ~clk;

    dp_regfile_alu #(.WIDTH(W), .NREGS(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs      (in_rs),
        .in_use_imm (in_use_imm),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_rd     (out_rd),
        .flags      (flags),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    function automatic int sgn(input int x);
        return (x >= TOP / 2) ? x - TOP : x;
    endfunction

    function automatic bit ovf(input int s);
        return (s > TOP / 2 - 1) || (s < -TOP / 2);
    endfunction

    // Reference: full-precision arithmetic, then reduce to W bits
    function automatic void model(input int op, input int a, input int b,
                                  output int res, output logic [3:0] fl, output bit wr);
        int full;
        bit c;
        bit v;
        int cin;
        c = 1'b0; v = 1'b0; wr = 1'b1; full = 0;
        cin = int'(m_flags[0]);
        case (op)
            0: full = a & b;
            1: full = a | b;
            2: full = a ^ b;
            3: begin full = a + b; c = full >= TOP; v = ovf(sgn(a) + sgn(b)); end
            4: begin full = a + (TOP - 1 - b) + 1; c = full >= TOP; v = ovf(sgn(a) - sgn(b)); end
            5: begin full = a + b + cin; c = full >= TOP; v = ovf(sgn(a) + sgn(b) + cin); end
            6: full = b;
            default: begin
`ifdef DP_MUL_EN
                full = a * b; c = (full / TOP) != 0;
`else
                full = 0; wr = 1'b0;
`endif
            end
        endcase
        res = full % TOP;
        fl  = wr ? {res >= TOP / 2, v, res == 0, c} : m_flags;
    endfunction

    task automatic send(input int op, input int rd, input int rs, input bit use_imm, input int imm);
        int         a;
        int         b;
        int         res;
        logic [3:0] fl;
        bit         wr;
        int         n;
        @(negedge clk);
        in_op = 3'(op); in_rd = AW'(rd); in_rs = AW'(rs);
        in_use_imm = use_imm; in_imm = W'(imm); in_valid = 1'b1;
        out_ready = bp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 64) begin
            if (out_valid) begin
                chk("hold_data", out_data, exp_data);
                chk("hold_rd", out_rd, exp_rd);
            end
            @(negedge clk);
            out_ready = bp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            n++;
        end
        last_stalls = n;
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        a = m_regs[rd];
        b = use_imm ? imm : m_regs[rs];
        model(op, a, b, res, fl, wr);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
`ifdef DP_MUL_EN
        if (op == 7) begin
            n = 0;
            while (!out_valid && n < 64) begin
                chk("mul_busy_ready", in_ready, 0);
                @(posedge clk);
                #1;
                n++;
            end
            chk("mul_latency_ok", n >= W, 1);
        end
`endif
        chk("out_valid", out_valid, 1);
        chk("out_data", out_data, res);
        chk("out_rd", out_rd, rd);
        chk("flags", flags, fl);
        if (wr) m_regs[rd] = res;
        m_flags  = fl;
        exp_data = res;
        exp_rd   = rd;
        dbg_addr = AW'(rd);
        #1;
        chk("dbg_rd", dbg_data, m_regs[rd]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_rd = '0; in_rs = '0;
        in_use_imm = 1'b0; in_imm = '0; out_ready = 1'b1; dbg_addr = '0; bp_rand = 1'b0;
        for (int i = 0; i < NR; i++) m_regs[i] = 0;
        m_flags = 4'b0000; exp_data = 0; exp_rd = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_flags", flags, 0);
        chk("rst_in_ready", in_ready, 1);

        // Wrap to zero with carry
        send(6, 0, 0, 1'b1, 8'hFF);
        send(3, 0, 0, 1'b1, 8'h01);
        chk("t1_data", out_data, 8'h00);
        chk("t1_flags", flags, 4'b0011);

        // Borrow and signed overflow
        send(6, 1, 0, 1'b1, 8'h00);
        send(4, 1, 0, 1'b1, 8'h01);
        chk("t2_sub_data", out_data, 8'hFF);
        chk("t2_sub_flags", flags, 4'b1000);
        send(6, 2, 0, 1'b1, 8'h7F);
        send(3, 2, 0, 1'b1, 8'h01);
        chk("t2_add_data", out_data, 8'h80);
        chk("t2_add_flags", flags, 4'b1100);

        // Dependent back-to-back with rd==rs
        send(6, 3, 0, 1'b1, 8'h05);
        send(3, 3, 3, 1'b0, 8'h00);
        chk("t3_no_stall", last_stalls, 0);
        chk("t3_data", out_data, 8'h0A);

        // Output stall holds the result
        send(6, 1, 0, 1'b1, 8'hAA);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            #1;
            chk("t4_in_ready", in_ready, 0);
            chk("t4_valid", out_valid, 1);
            chk("t4_data", out_data, 8'hAA);
            chk("t4_rd", out_rd, 1);
        end
        in_valid = 1'b0;
        send(2, 2, 1, 1'b0, 8'h00);

        // Opcode 111: MUL or NOP depending on build
        send(6, 0, 0, 1'b1, 8'h10);
        send(7, 0, 0, 1'b1, 8'h10);
`ifdef DP_MUL_EN
        chk("t6_mul_data", out_data, 8'h00);
        chk("t6_mul_flags", flags, 4'b0011);
`else
        chk("t6_nop_data", out_data, 8'h00);
        dbg_addr = '0;
        #1;
        chk("t6_nop_r0", dbg_data, 8'h10);
`endif

        bp_rand = 1'b1;
        for (int k = 0; k < 300; k++) begin
            send($urandom_range(0, 7), $urandom_range(0, NR - 1), $urandom_range(0, NR - 1),
                 1'($urandom_range(0, 1)), $urandom_range(0, TOP - 1));
        end
        bp_rand = 1'b0;

        // Reset while a result is pending
        send(6, 2, 0, 1'b1, 8'h33);
        @(negedge clk);
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_flags", flags, 0);
        for (int i = 0; i < NR; i++) begin
            dbg_addr = AW'(i);
            #1;
            chk("t5_dbg", dbg_data, 0);
            m_regs[i] = 0;
        end
        m_flags = 4'b0000;
        send(3, 1, 1, 1'b1, 8'h01);
        chk("t5_after_rst", out_data, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
